// File: rtl/exec_stage_md.sv
// Execute stage: operand forwarding, branch compare, ALU and an optional
// M-extension unit (multiply/divide FSM) enabled by the EXEC_STAGE_MD_EN macro.
module exec_stage_md #(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [31:0]             inst_in,
  input  logic [XLEN-1:0]         imm_in,
  input  logic [NFWD*XLEN-1:0]    rs1_fwd,
  input  logic [NFWD*XLEN-1:0]    rs2_fwd,
  input  logic [$clog2(NFWD)-1:0] rs1_sel,
  input  logic [$clog2(NFWD)-1:0] rs2_sel,
  input  logic                    a_sel,
  input  logic                    b_sel,
  input  logic [3:0]              alu_sel,
  input  logic                    br_un,
  input  logic                    md_en,
  input  logic [2:0]              md_op,
  output logic                    br_eq,
  output logic                    br_lt,
  output logic [XLEN-1:0]         alu_out,
  output logic [XLEN-1:0]         store_data,
  output logic                    busy,
  output logic                    out_valid,
  output logic [XLEN-1:0]         result_reg,
  output logic [XLEN-1:0]         pc_out,
  output logic [31:0]             inst_out,
  output logic [1:0]              fsm_state
);

  localparam int SW  = $clog2(NFWD);
  localparam int SHW = $clog2(XLEN);

  // ALU opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
  // 8 OR, 9 AND, 10 pass B; anything else yields zero.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASB = 4'd10;

  logic [XLEN-1:0] rs1, rs2, op_a, op_b;
  logic [SHW-1:0]  shamt;

  // A select value with no matching source leaves the operand at zero.
  always_comb begin
    rs1 = '0;
    rs2 = '0;
    for (int k = 0; k < NFWD; k++) begin
      if (rs1_sel == SW'(k)) rs1 = rs1_fwd[k*XLEN +: XLEN];
      if (rs2_sel == SW'(k)) rs2 = rs2_fwd[k*XLEN +: XLEN];
    end
  end

  assign op_a       = a_sel ? pc_in  : rs1;
  assign op_b       = b_sel ? imm_in : rs2;
  assign shamt      = op_b[SHW-1:0];
  assign store_data = rs2;
  assign br_eq      = (rs1 == rs2);
  assign br_lt      = br_un ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLL:  alu_out = op_a << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SRL:  alu_out = op_a >> shamt;
      ALU_SRA:  alu_out = $signed(op_a) >>> shamt;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_AND:  alu_out = op_a & op_b;
      ALU_PASB: alu_out = op_b;
      default:  alu_out = '0;
    endcase
  end

  // Handshake: busy is the inverse of ready. An instruction is consumed on a
  // rising edge where in_valid=1 and busy=0; while busy=1 upstream holds it.

`ifdef EXEC_STAGE_MD_EN
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            issue;
  logic [XLEN-1:0] md_a, md_b, md_pc;
  logic [31:0]     md_inst;
  logic [2:0]      md_op_q;
  logic [XLEN-1:0] div_rem, div_quo, div_dvs;
  logic [CW-1:0]   div_cnt;
  logic [XLEN-1:0] dvd_abs, dvs_abs, step_rem, step_quo;
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] quo_fix, rem_fix, div_res, mul_res;
  logic            div_sgn_in, neg_q, neg_r, a_sgn, b_sgn;
  logic signed [2*XLEN+1:0] mul_a, mul_b, mul_p;
  logic            unused_md;

  assign issue = in_valid & md_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = md_op[2] ? DIV : MUL;
      MUL:     state_nxt = IDLE;
      DIV:     if (div_cnt == CW'(XLEN-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = rst_n & (((state == IDLE) & issue) | (state == DIV));
    fsm_state = state;
  end

  // Divide runs on magnitudes; signs are reapplied from the latched operands.
  assign div_sgn_in = ~md_op[0];
  assign dvd_abs    = (div_sgn_in & rs1[XLEN-1]) ? -rs1 : rs1;
  assign dvs_abs    = (div_sgn_in & rs2[XLEN-1]) ? -rs2 : rs2;
  assign div_shift  = {div_rem, div_quo[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, div_dvs};
  assign step_rem   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign step_quo   = {div_quo[XLEN-2:0], ~div_diff[XLEN]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_a    <= '0;
      md_b    <= '0;
      md_pc   <= '0;
      md_inst <= '0;
      md_op_q <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_dvs <= '0;
      div_cnt <= '0;
    end else if (state == IDLE && issue) begin
      md_a    <= rs1;
      md_b    <= rs2;
      md_pc   <= pc_in;
      md_inst <= inst_in;
      md_op_q <= md_op;
      div_rem <= '0;
      div_quo <= dvd_abs;
      div_dvs <= dvs_abs;
      div_cnt <= '0;
    end else if (state == DIV) begin
      div_rem <= step_rem;
      div_quo <= step_quo;
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign neg_q   = ~md_op_q[0] & (md_a[XLEN-1] ^ md_b[XLEN-1]);
  assign neg_r   = ~md_op_q[0] & md_a[XLEN-1];
  assign quo_fix = neg_q ? -div_quo : div_quo;
  assign rem_fix = neg_r ? -div_rem : div_rem;

  always_comb begin
    if (md_b == '0) div_res = md_op_q[1] ? md_a : '1;
    else            div_res = md_op_q[1] ? rem_fix : quo_fix;
  end

  // One signed multiplier covers ss/su/uu by choosing each operand's extension.
  assign a_sgn   = (md_op_q[1:0] != 2'b11);
  assign b_sgn   = ~md_op_q[1];
  assign mul_a   = {{(XLEN+2){a_sgn & md_a[XLEN-1]}}, md_a};
  assign mul_b   = {{(XLEN+2){b_sgn & md_b[XLEN-1]}}, md_b};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (md_op_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  assign unused_md = ^{md_op_q[2], mul_p[2*XLEN+1:2*XLEN]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_reg <= '0;
      pc_out     <= '0;
      inst_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !md_en) begin
            out_valid  <= 1'b1;
            result_reg <= alu_out;
            pc_out     <= pc_in;
            inst_out   <= inst_in;
          end else begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          out_valid  <= 1'b1;
          result_reg <= mul_res;
          pc_out     <= md_pc;
          inst_out   <= md_inst;
        end
        DONE: begin
          out_valid  <= 1'b1;
          result_reg <= div_res;
          pc_out     <= md_pc;
          inst_out   <= md_inst;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end
`else
  logic unused_md;

  assign busy      = 1'b0;
  assign fsm_state = 2'b00;
  assign unused_md = ^{md_en, md_op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_reg <= '0;
      pc_out     <= '0;
      inst_out   <= '0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      result_reg <= alu_out;
      pc_out     <= pc_in;
      inst_out   <= inst_in;
    end else begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_exec_stage_md.sv
// Bench for exec_stage_md: transaction-level model of results and latency,
// one negedge compare process, plus literal expectations on key vectors.
module tb_exec_stage_md;
  localparam int XLEN = 32;
  localparam int NFWD = 3;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
  localparam logic [3:0] OP_OR = 4'd8, OP_AND = 4'd9, OP_PASB = 4'd10;

  logic        clk, rst_n, in_valid;
  logic [31:0] pc_in, inst_in, imm_in;
  logic [31:0] src1 [3];
  logic [31:0] src2 [3];
  logic [95:0] rs1_fwd, rs2_fwd;
  logic [1:0]  rs1_sel, rs2_sel;
  logic        a_sel, b_sel, br_un, md_en;
  logic [3:0]  alu_sel;
  logic [2:0]  md_op;
  logic        br_eq, br_lt, busy, out_valid;
  logic [31:0] alu_out, store_data, result_reg, pc_out, inst_out;
  logic [1:0]  fsm_state;

  logic        exp_busy, exp_valid;
  logic [31:0] exp_result, exp_pc, exp_inst;
  int          n_checks, n_fail, busy_total, bt;
  bit          checking;

  assign rs1_fwd = {src1[2], src1[1], src1[0]};
  assign rs2_fwd = {src2[2], src2[1], src2[0]};

  exec_stage_md #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_in(pc_in), .inst_in(inst_in),
    .imm_in(imm_in), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_sel(rs1_sel),
    .rs2_sel(rs2_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .br_un(br_un),
    .md_en(md_en), .md_op(md_op), .br_eq(br_eq), .br_lt(br_lt), .alu_out(alu_out),
    .store_data(store_data), .busy(busy), .out_valid(out_valid), .result_reg(result_reg),
    .pc_out(pc_out), .inst_out(inst_out), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] v0, v1, v2);
    case (sel)
      2'd0:    return v0;
      2'd1:    return v1;
      2'd2:    return v2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD:  t = 64'(a) + 64'(b);
      OP_SUB:  t = 64'(sa - sb);
      OP_SLL:  t = 64'(a) << b[4:0];
      OP_SLT:  t = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: t = (64'(a) < 64'(b)) ? 64'd1 : 64'd0;
      OP_XOR:  t = 64'(a ^ b);
      OP_SRL:  t = 64'(a) >> b[4:0];
      OP_SRA:  t = 64'(sa >>> b[4:0]);
      OP_OR:   t = 64'(a | b);
      OP_AND:  t = 64'(a & b);
      OP_PASB: t = 64'(b);
      default: t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    r  = 32'd0;
    case (op)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * longint'(ub));
      3'd3:       p = ua * ub;
      3'd4: if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
            else r = 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
            else r = 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    if (op == 3'd0) r = p[31:0];
    else if (op <= 3'd3) r = p[63:32];
    return r;
  endfunction

  // Compare process
  always @(negedge clk) begin : compare
    logic [31:0] ea, eb;
    if (checking) begin
      if (busy) busy_total++;
      check("busy", busy, exp_busy);
      check("out_valid", out_valid, exp_valid);
      check("result_reg", result_reg, exp_result);
      check("pc_out", pc_out, exp_pc);
      check("inst_out", inst_out, exp_inst);
      ea = pick(rs1_sel, src1[0], src1[1], src1[2]);
      eb = pick(rs2_sel, src2[0], src2[1], src2[2]);
      check("store_data", store_data, eb);
      check("br_eq", br_eq, (ea == eb));
      check("br_lt", br_lt,
            br_un ? (ea < eb) : (longint'($signed(ea)) < longint'($signed(eb))));
      check("alu_out", alu_out, ref_alu(alu_sel, a_sel ? pc_in : ea, b_sel ? imm_in : eb));
    end
  end

  // Drivers: one instruction, held until it is consumed; latency from the model.
  task automatic op(input logic [31:0] pc, inst, imm, input logic [1:0] s1,
                    input logic [31:0] v1, input logic [1:0] s2, input logic [31:0] v2,
                    input logic as, bs, input logic [3:0] aop, input logic un, md,
                    input logic [2:0] mop, input bit scramble);
    logic [31:0] a, b, res;
    logic        md_path;
    int          nbusy, lat, b0;
    for (int k = 0; k < 3; k++) begin
      src1[k] = $urandom;
      src2[k] = $urandom;
    end
    if (s1 < 3) src1[s1] = v1;
    if (s2 < 3) src2[s2] = v2;
    a = (s1 < 3) ? v1 : 32'd0;
    b = (s2 < 3) ? v2 : 32'd0;
    pc_in = pc; inst_in = inst; imm_in = imm; rs1_sel = s1; rs2_sel = s2;
    a_sel = as; b_sel = bs; alu_sel = aop; br_un = un; md_en = md; md_op = mop;
    in_valid = 1'b1;
`ifdef EXEC_STAGE_MD_EN
    md_path = md;
`else
    md_path = 1'b0;
`endif
    if (md_path) begin
      res   = ref_md(mop, a, b);
      nbusy = mop[2] ? XLEN + 1 : 1;
    end else begin
      res   = ref_alu(aop, as ? pc : a, bs ? imm : b);
      nbusy = 0;
    end
    lat = nbusy + 1;
    b0  = busy_total;
    for (int c = 1; c <= lat; c++) begin
      exp_busy = (c <= nbusy);
      if (scramble && c >= 2 && c <= nbusy) begin
        for (int k = 0; k < 3; k++) begin
          src1[k] = $urandom;
          src2[k] = $urandom;
        end
      end
      @(posedge clk);
      #1;
      if (c < lat) exp_valid = 1'b0;
      else begin
        exp_valid = 1'b1; exp_result = res; exp_pc = pc; exp_inst = inst;
      end
    end
    check("busy_cycles", busy_total - b0, nbusy);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    md_en    = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_busy = 1'b0;
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; busy_total = 0;
    rst_n = 1'b0; in_valid = 1'b0; pc_in = '0; inst_in = '0; imm_in = '0;
    for (int k = 0; k < 3; k++) begin src1[k] = '0; src2[k] = '0; end
    rs1_sel = '0; rs2_sel = '0; a_sel = 0; b_sel = 0; alu_sel = '0; br_un = 0;
    md_en = 0; md_op = '0;
    exp_busy = 0; exp_valid = 0; exp_result = '0; exp_pc = '0; exp_inst = '0;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_result", result_reg, 32'd0);
    check("reset_out_valid", out_valid, 1'b0);

    // ADD with rs1 forwarded from source 1
    bt = busy_total;
    op(32'h100, 32'h00208033, 0, 2'd1, 32'd5, 2'd0, 32'd7, 0, 0, OP_ADD, 0, 0, 3'd0, 0);
    check("add_lit", result_reg, 32'd12);
    check("add_pc_lit", pc_out, 32'h100);
    check("add_no_busy", busy_total - bt, 0);
    op(32'h200, 32'h11, 32'h10, 2'd0, 32'd1, 2'd0, 32'd2, 1, 1, OP_SUB, 0, 0, 3'd0, 0);
    check("sub_pc_imm_lit", result_reg, 32'h1F0);
    op(32'h204, 32'h12, 0, 2'd2, 32'hFFFFFFFF, 2'd1, 32'd1, 0, 0, OP_SLT, 0, 0, 3'd0, 0);
    check("slt_lit", result_reg, 32'd1);
    check("br_lt_signed_lit", br_lt, 1'b1);
    op(32'h208, 32'h13, 0, 2'd2, 32'hFFFFFFFF, 2'd1, 32'd1, 0, 0, OP_SLTU, 1, 0, 3'd0, 0);
    check("sltu_lit", result_reg, 32'd0);
    check("br_lt_unsigned_lit", br_lt, 1'b0);
    op(32'h20C, 32'h14, 32'd4, 2'd0, 32'h80000000, 2'd0, 0, 0, 1, OP_SRA, 0, 0, 3'd0, 0);
    check("sra_lit", result_reg, 32'hF8000000);
    op(32'h210, 32'h15, 32'd4, 2'd0, 32'h80000000, 2'd0, 0, 0, 1, OP_SRL, 0, 0, 3'd0, 0);
    check("srl_lit", result_reg, 32'h08000000);
    op(32'h214, 32'h16, 0, 2'd1, 32'd1, 2'd2, 32'd31, 0, 0, OP_SLL, 0, 0, 3'd0, 0);
    check("sll_lit", result_reg, 32'h80000000);
    op(32'h218, 32'h17, 0, 2'd0, 32'hF0F0A5A5, 2'd1, 32'h0FF00FF0, 0, 0, OP_XOR, 0, 0, 3'd0, 0);
    op(32'h21C, 32'h18, 0, 2'd0, 32'hF0F0A5A5, 2'd1, 32'h0FF00FF0, 0, 0, OP_OR, 0, 0, 3'd0, 0);
    op(32'h220, 32'h19, 0, 2'd0, 32'hF0F0A5A5, 2'd1, 32'h0FF00FF0, 0, 0, OP_AND, 0, 0, 3'd0, 0);
    op(32'h224, 32'h1A, 32'hABCD0000, 2'd0, 32'd9, 2'd0, 0, 0, 1, OP_PASB, 0, 0, 3'd0, 0);
    // Out-of-range selects give zero operands
    op(32'h228, 32'h1B, 0, 2'd3, 32'd0, 2'd3, 32'd0, 0, 0, OP_ADD, 0, 0, 3'd0, 0);
    check("sel_oob_result_lit", result_reg, 32'd0);
    check("sel_oob_store_lit", store_data, 32'd0);
    op(32'h22C, 32'h1C, 0, 2'd2, 32'h1234, 2'd2, 32'h1234, 0, 0, OP_SUB, 0, 0, 3'd0, 0);
    check("br_eq_lit", br_eq, 1'b1);
    idle(3);

`ifdef EXEC_STAGE_MD_EN
    bt = busy_total;
    op(32'h300, 32'h21, 0, 2'd0, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 0, 0, OP_ADD, 0, 1, 3'd3, 0);
    check("mulhu_lit", result_reg, 32'hFFFFFFFE);
    check("mulhu_busy_lit", busy_total - bt, 1);
    op(32'h304, 32'h22, 0, 2'd0, 32'd7, 2'd0, 32'hFFFFFFFD, 0, 0, OP_ADD, 0, 1, 3'd0, 0);
    check("mul_lit", result_reg, 32'hFFFFFFEB);
    op(32'h308, 32'h23, 0, 2'd0, 32'h80000000, 2'd0, 32'h80000000, 0, 0, OP_ADD, 0, 1, 3'd1, 0);
    check("mulh_lit", result_reg, 32'h40000000);
    op(32'h30C, 32'h24, 0, 2'd0, 32'hFFFFFFFF, 2'd0, 32'hFFFFFFFF, 0, 0, OP_ADD, 0, 1, 3'd2, 0);
    check("mulhsu_lit", result_reg, 32'hFFFFFFFF);
    bt = busy_total;
    op(32'h310, 32'h25, 0, 2'd0, 32'h80000000, 2'd1, 32'hFFFFFFFF, 0, 0, OP_ADD, 0, 1, 3'd4, 1);
    check("div_ovf_lit", result_reg, 32'h80000000);
    check("div_busy_lit", busy_total - bt, 33);
    op(32'h314, 32'h26, 0, 2'd0, 32'h80000000, 2'd1, 32'hFFFFFFFF, 0, 0, OP_ADD, 0, 1, 3'd6, 0);
    check("rem_ovf_lit", result_reg, 32'd0);
    op(32'h318, 32'h27, 0, 2'd0, 32'd100, 2'd0, 32'd0, 0, 0, OP_ADD, 0, 1, 3'd5, 0);
    check("divu_zero_lit", result_reg, 32'hFFFFFFFF);
    op(32'h31C, 32'h28, 0, 2'd0, 32'd100, 2'd0, 32'd0, 0, 0, OP_ADD, 0, 1, 3'd7, 1);
    check("remu_zero_lit", result_reg, 32'd100);
    op(32'h320, 32'h29, 0, 2'd1, 32'hFFFFFFF9, 2'd2, 32'd2, 0, 0, OP_ADD, 0, 1, 3'd4, 0);
    check("div_neg_lit", result_reg, 32'hFFFFFFFD);
    op(32'h324, 32'h2A, 0, 2'd1, 32'hFFFFFFF9, 2'd2, 32'd2, 0, 0, OP_ADD, 0, 1, 3'd6, 0);
    check("rem_neg_lit", result_reg, 32'hFFFFFFFF);
    op(32'h328, 32'h2B, 0, 2'd0, 32'd20, 2'd0, 32'd0, 0, 0, OP_ADD, 0, 1, 3'd4, 0);
    check("div_zero_lit", result_reg, 32'hFFFFFFFF);
    op(32'h32C, 32'h2C, 0, 2'd0, 32'd1000, 2'd0, 32'd7, 0, 0, OP_ADD, 0, 1, 3'd5, 0);
    check("divu_lit", result_reg, 32'd142);
    op(32'h330, 32'h2D, 0, 2'd0, 32'd1000, 2'd0, 32'd7, 0, 0, OP_ADD, 0, 1, 3'd7, 1);
    check("remu_lit", result_reg, 32'd6);

    // Reset while the divider is on iteration 10
    src1[0] = 32'h12345678; src2[0] = 32'd3; rs1_sel = 0; rs2_sel = 0;
    pc_in = 32'h400; inst_in = 32'h31; a_sel = 0; b_sel = 0; alu_sel = OP_ADD;
    md_en = 1; md_op = 3'd4; in_valid = 1;
    exp_busy = 1;
    repeat (11) begin
      @(posedge clk);
      #1 exp_valid = 0;
    end
    rst_n = 0;
    exp_busy = 0; exp_valid = 0; exp_result = '0; exp_pc = '0; exp_inst = '0;
    #1;
    check("rst_busy_lit", busy, 1'b0);
    check("rst_out_valid_lit", out_valid, 1'b0);
    check("rst_result_lit", result_reg, 32'd0);
    in_valid = 0; md_en = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    op(32'h500, 32'h41, 0, 2'd0, 32'd10, 2'd1, 32'd20, 0, 0, OP_ADD, 0, 0, 3'd0, 0);
    check("post_rst_add_lit", result_reg, 32'd30);
    idle(40);
`else
    bt = busy_total;
    op(32'h300, 32'h51, 0, 2'd0, 32'd3, 2'd0, 32'd4, 0, 0, OP_ADD, 0, 1, 3'd4, 0);
    check("md_off_add_lit", result_reg, 32'd7);
    check("md_off_busy_lit", busy_total - bt, 0);
    idle(3);
`endif

    idle(2);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
